// File: rtl/dcache_dirty_array_if.sv
// ============================================================================
// dcache_dirty_array_if : read/write/insert/scan bundle for the dcache dirty array
// Scan signals exist only with DCACHE_DIRTY_SCAN_EN.  Rev 1.0
// ============================================================================
`default_nettype none

interface dcache_dirty_array_if #(
   parameter int SETS   = 64,
   parameter int WAYS   = 4,
   parameter int WPORTS = 2
);
   localparam int SW = $clog2(SETS);
   localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;

   logic                   init_i;
   logic                   busy_o;
   logic                   rd_en_i;
   logic [SW-1:0]          rd_set_i;
   logic [WW-1:0]          rd_way_i;
   logic                   rd_dirty_o;
   logic [WAYS-1:0]        rd_mask_o;
   logic [WPORTS-1:0]      wr_en_i;
   logic [WPORTS*SW-1:0]   wr_set_i;
   logic [WPORTS*WW-1:0]   wr_way_i;
   logic [WPORTS-1:0]      wr_val_i;
   logic                   ins_en_i;
   logic [SW-1:0]          ins_set_i;
   logic [WW-1:0]          ins_way_i;
   logic                   ins_dirty_i;
`ifdef DCACHE_DIRTY_SCAN_EN
   logic                   scan_req_i;
   logic [SW-1:0]          scan_start_i;
   logic                   scan_valid_o;
   logic                   scan_none_o;
   logic [SW-1:0]          scan_set_o;
   logic [WW-1:0]          scan_way_o;
   logic                   scan_ack_i;

   modport slave (
      input  init_i, rd_en_i, rd_set_i, rd_way_i, wr_en_i, wr_set_i, wr_way_i, wr_val_i,
             ins_en_i, ins_set_i, ins_way_i, ins_dirty_i, scan_req_i, scan_start_i, scan_ack_i,
      output busy_o, rd_dirty_o, rd_mask_o, scan_valid_o, scan_none_o, scan_set_o, scan_way_o
   );
   modport master (
      output init_i, rd_en_i, rd_set_i, rd_way_i, wr_en_i, wr_set_i, wr_way_i, wr_val_i,
             ins_en_i, ins_set_i, ins_way_i, ins_dirty_i, scan_req_i, scan_start_i, scan_ack_i,
      input  busy_o, rd_dirty_o, rd_mask_o, scan_valid_o, scan_none_o, scan_set_o, scan_way_o
   );
`else
   modport slave (
      input  init_i, rd_en_i, rd_set_i, rd_way_i, wr_en_i, wr_set_i, wr_way_i, wr_val_i,
             ins_en_i, ins_set_i, ins_way_i, ins_dirty_i,
      output busy_o, rd_dirty_o, rd_mask_o
   );
   modport master (
      output init_i, rd_en_i, rd_set_i, rd_way_i, wr_en_i, wr_set_i, wr_way_i, wr_val_i,
             ins_en_i, ins_set_i, ins_way_i, ins_dirty_i,
      input  busy_o, rd_dirty_o, rd_mask_o
   );
`endif

endinterface

`default_nettype wire

// File: rtl/dcache_dirty_array.sv
// ============================================================================
// dcache_dirty_array : SETS x WAYS dirty-bit store, multi-port writes, swept clear
// Optional dirty-line search enabled by DCACHE_DIRTY_SCAN_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module dcache_dirty_array #(
   parameter int SETS   = 64,
   parameter int WAYS   = 4,
   parameter int WPORTS = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   dcache_dirty_array_if.slave   bus
);
   localparam int SW = $clog2(SETS);
   localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;

`ifdef DCACHE_DIRTY_SCAN_EN
   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_IDLE = 2'd1,
      ST_SCAN = 2'd2,
      ST_DONE = 2'd3
   } state_t;
`else
   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_IDLE = 1'b1
   } state_t;
`endif

   state_t                      state_q, state_d;
   logic [SW-1:0]               idx_q, idx_d;
   logic [SETS-1:0][WAYS-1:0]   mem_q, mem_d;
   logic                        rd_dirty_q;
   logic [WAYS-1:0]             rd_mask_q;
   logic                        w_busy;

   assign w_busy = (state_q == ST_INIT);

   // Post-write array image: reads and the scan both observe this cycle's writes.
   always_comb begin
      mem_d = mem_q;
      if (w_busy) begin
         mem_d[idx_q] = '0;
      end else begin
         for (int p = 0; p < WPORTS; p++) begin
            if (bus.wr_en_i[p]) begin
               mem_d[bus.wr_set_i[p*SW +: SW]][bus.wr_way_i[p*WW +: WW]] = bus.wr_val_i[p];
            end
         end
         if (bus.ins_en_i) begin
            mem_d[bus.ins_set_i][bus.ins_way_i] = bus.ins_dirty_i;
         end
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

`ifdef DCACHE_DIRTY_SCAN_EN
   logic [SW-1:0]   cnt_q, cnt_d;
   logic [SW-1:0]   res_set_q, res_set_d;
   logic [WW-1:0]   res_way_q, res_way_d;
   logic            res_none_q, res_none_d;
   logic [WAYS-1:0] w_row;
   logic [WW-1:0]   w_low_way;

   assign w_row = mem_d[idx_q];

   always_comb begin
      w_low_way = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (w_row[w]) w_low_way = WW'(w);
      end
   end
`endif

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
`ifdef DCACHE_DIRTY_SCAN_EN
      cnt_d      = cnt_q;
      res_set_d  = res_set_q;
      res_way_d  = res_way_q;
      res_none_d = res_none_q;
`endif
      case (state_q)
         ST_INIT: begin
            idx_d = idx_q + 1'b1;
            if (idx_q == SW'(SETS - 1)) begin
               state_d = ST_IDLE;
               idx_d   = '0;
            end
         end
`ifdef DCACHE_DIRTY_SCAN_EN
         ST_IDLE: begin
            if (bus.scan_req_i) begin
               state_d = ST_SCAN;
               idx_d   = bus.scan_start_i;
               cnt_d   = '0;
            end
         end
         ST_SCAN: begin
            if (|w_row) begin
               state_d    = ST_DONE;
               res_set_d  = idx_q;
               res_way_d  = w_low_way;
               res_none_d = 1'b0;
            end else if (cnt_q == SW'(SETS - 1)) begin
               state_d    = ST_DONE;
               res_set_d  = '0;
               res_way_d  = '0;
               res_none_d = 1'b1;
            end else begin
               idx_d = idx_q + 1'b1;
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DONE: begin
            if (bus.scan_ack_i) state_d = ST_IDLE;
         end
`else
         ST_IDLE: begin
            state_d = ST_IDLE;
         end
`endif
         default: begin
            state_d = ST_INIT;
            idx_d   = '0;
         end
      endcase
      // A new init overrides everything, including an in-flight scan.
      if (bus.init_i) begin
         state_d = ST_INIT;
         idx_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_INIT;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

`ifdef DCACHE_DIRTY_SCAN_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q      <= '0;
         res_set_q  <= '0;
         res_way_q  <= '0;
         res_none_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         res_set_q  <= res_set_d;
         res_way_q  <= res_way_d;
         res_none_q <= res_none_d;
      end
   end

   assign bus.scan_valid_o = (state_q == ST_DONE);
   assign bus.scan_none_o  = bus.scan_valid_o & res_none_q;
   assign bus.scan_set_o   = bus.scan_valid_o ? res_set_q : '0;
   assign bus.scan_way_o   = bus.scan_valid_o ? res_way_q : '0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_dirty_q <= 1'b0;
         rd_mask_q  <= '0;
      end else if (bus.rd_en_i) begin
         if (w_busy) begin
            rd_dirty_q <= 1'b0;
            rd_mask_q  <= '0;
         end else begin
            rd_dirty_q <= mem_d[bus.rd_set_i][bus.rd_way_i];
            rd_mask_q  <= mem_d[bus.rd_set_i];
         end
      end
   end

   assign bus.busy_o     = w_busy;
   assign bus.rd_dirty_o = rd_dirty_q;
   assign bus.rd_mask_o  = rd_mask_q;

endmodule

`default_nettype wire
